spi_xact_arbiter: RTL and testbench
===================================

// Module: spi_xact_arbiter
// PURPOSE
//  Shares one byte-level SPI PHY between two requester ports and frames transactions.
//  Each requester streams bytes with a LAST flag; a granted frame owns the PHY until LAST completes.
//  Drives chip-select with programmable setup/hold/gap timing and routes received bytes back to the owner.
//  Sits between the CPU-side SPI clients (flash loader, debug port) and the SPI PHY.
// PARAMETERS
//  CS_SETUP  2  i_clk cycles CS low before first byte is issued (min 1)
//  CS_HOLD   2  i_clk cycles CS stays low after last received byte (min 1)
//  CS_GAP    4  i_clk cycles CS stays high before next grant (min 1)
// PORTS
//  i_clk          in   1  system clock; all logic on posedge
//  i_rst          in   1  synchronous reset, active-high
//  i_req0_valid   in   1  requester 0 has a byte to send
//  i_req0_data    in   8  requester 0 tx byte
//  i_req0_last    in   1  byte is last of requester 0 frame
//  o_req0_ready   out  1  byte accepted when valid&&ready
//  o_rsp0_valid   out  1  one-cycle strobe: rx byte for requester 0
//  o_rsp0_data    out  8  rx byte for requester 0
//  i_req1_*/o_req1_ready/o_rsp1_*  same as port 0, requester 1
//  o_phy_wr       out  1  one-cycle strobe: start PHY byte transfer
//  o_phy_data     out  8  byte to shift out
//  i_phy_busy     in   1  PHY shifting; no o_phy_wr while high
//  i_phy_rx_valid in   1  one-cycle strobe: PHY finished byte
//  i_phy_rx_data  in   8  byte shifted in
//  o_cs_n         out  1  SPI chip select, active-low
//  o_grant        out  2  one-hot current owner; 0 when idle
// BEHAVIOUR
//  Reset values: o_cs_n=1, o_grant=0, o_phy_wr=0, o_phy_data=0, o_rsp*_valid=0, o_rsp*_data=0,
//   pending=0, last_grant=1 (so port 0 wins first tie), state=IDLE, counter=0.
//  States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//  IDLE: o_cs_n=1. If any i_reqN_valid: grant; both valid -> port != last_grant; set last_grant,
//   o_grant, o_cs_n=0 next cycle, load counter CS_SETUP-1, go SETUP.
//  SETUP: count down; at 0 go XFER. Exactly CS_SETUP cycles of CS low precede first o_phy_wr.
//  XFER: o_reqN_ready (combinational) = state==XFER && grant==N && !pending && !i_phy_busy;
//   non-granted port ready always 0. On handshake: next cycle o_phy_wr=1 for one cycle,
//   o_phy_data=byte, pending=1, last_flag=i_reqN_last.
//  i_phy_rx_valid while pending: next cycle o_rspN_valid=1 (owner only), o_rspN_data=i_phy_rx_data,
//   pending=0; if last_flag go HOLD, load CS_HOLD-1. Back-to-back min: 1 byte per 2 cycles + PHY time.
//  i_phy_rx_valid with pending=0 or outside XFER: ignored, no rsp strobe.
//  Requester may drop valid mid-frame; CS stays low, grant held until a LAST byte completes.
//  HOLD: CS low, count down; at 0 o_cs_n=1, o_grant=0, load CS_GAP-1, go GAP.
//  GAP: CS high, no ready; at 0 go IDLE. Requests during HOLD/GAP wait; none lost.
//  Simultaneous new request and GAP expiry: granted on first IDLE cycle (one IDLE cycle minimum).
//  Counter width: $clog2 of max parameter +1; no wrap (reloaded each state entry).
//  i_rst mid-frame: all outputs to reset values next edge, CS released immediately, in-flight
//   PHY byte result discarded; frame is not resumed.
//  o_phy_wr never asserted while i_phy_busy=1 or pending=1.
// TESTING
//  Req0 single byte 0x9F LAST, PHY echoes 0xC2 -> CS low 2 cycles before o_phy_wr, o_rsp0 0xC2, CS high 2 after.
//  Req0 and req1 valid same cycle after reset -> port 0 granted; after frame+4-cycle gap port 1 granted.
//  Req1 frame 0x03,0x00,0x10,0x00(LAST) -> 4 wr strobes, 4 rsp1 strobes, CS low continuously, rsp0 never.
//  Hold i_phy_busy=1 for 10 cycles in XFER -> no ready, no o_phy_wr until busy falls.
//  Assert i_rst mid-frame after 2nd byte wr -> next edge o_cs_n=1, o_grant=0; late rx_valid gives no rsp.
//  Spurious i_phy_rx_valid in IDLE with data 0x55 -> no rsp strobe, state stays IDLE.

Source files
------------

// File: rtl/spi_xact_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_xact_arbiter_if
// Brief    : Requester, response and PHY signal bundle for spi_xact_arbiter.
//            The arbiter uses the slave modport. Whatever drives the
//            requesters and models the PHY uses the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_xact_arbiter_if;
  // Requester 0
  logic       i_req0_valid;
  logic [7:0] i_req0_data;
  logic       i_req0_last;
  logic       o_req0_ready;
  logic       o_rsp0_valid;
  logic [7:0] o_rsp0_data;
  // Requester 1
  logic       i_req1_valid;
  logic [7:0] i_req1_data;
  logic       i_req1_last;
  logic       o_req1_ready;
  logic       o_rsp1_valid;
  logic [7:0] o_rsp1_data;
  // PHY side and chip select
  logic       o_phy_wr;
  logic [7:0] o_phy_data;
  logic       i_phy_busy;
  logic       i_phy_rx_valid;
  logic [7:0] i_phy_rx_data;
  logic       o_cs_n;
  logic [1:0] o_grant;

  modport slave (
    input  i_req0_valid, i_req0_data, i_req0_last,
    output o_req0_ready, o_rsp0_valid, o_rsp0_data,
    input  i_req1_valid, i_req1_data, i_req1_last,
    output o_req1_ready, o_rsp1_valid, o_rsp1_data,
    output o_phy_wr, o_phy_data,
    input  i_phy_busy, i_phy_rx_valid, i_phy_rx_data,
    output o_cs_n, o_grant
  );

  modport master (
    output i_req0_valid, i_req0_data, i_req0_last,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_data,
    output i_req1_valid, i_req1_data, i_req1_last,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_data,
    input  o_phy_wr, o_phy_data,
    output i_phy_busy, i_phy_rx_valid, i_phy_rx_data,
    input  o_cs_n, o_grant
  );
endinterface
`default_nettype wire

// File: rtl/spi_xact_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_xact_arbiter
// Brief    : Shares one byte-level SPI PHY between two requesters. A granted
//            frame owns the PHY and chip select until its LAST byte returns.
//            Chip select has programmable setup, hold and gap timing.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xact_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_xact_arbiter_if.slave bus
);

  localparam int c_MAX_P = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                           ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int c_CNT_W = $clog2(c_MAX_P + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(CS_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(CS_HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LD   = c_CNT_W'(CS_GAP - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SETUP = 3'd1;
  localparam logic [2:0] c_XFER  = 3'd2;
  localparam logic [2:0] c_HOLD  = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               pending_q, pending_d;
  logic               last_flag_q, last_flag_d;
  logic               cs_n_q, cs_n_d;
  logic               phy_wr_q, phy_wr_d;
  logic [7:0]         phy_data_q, phy_data_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [7:0]         rsp0_data_q, rsp0_data_d;
  logic [7:0]         rsp1_data_q, rsp1_data_d;

  logic       w_xfer_free, w_ready0, w_ready1, w_hs;
  logic       w_hs_last, w_rx, w_any_req, w_pick1;
  logic [7:0] w_hs_data;

  // Only the owner may hand over a byte, and only when nothing is in flight.
  assign w_xfer_free = (state_q == c_XFER) && !pending_q && !bus.i_phy_busy;
  assign w_ready0    = w_xfer_free && grant_q[0];
  assign w_ready1    = w_xfer_free && grant_q[1];
  assign w_hs        = (w_ready0 && bus.i_req0_valid) || (w_ready1 && bus.i_req1_valid);
  assign w_hs_data   = grant_q[1] ? bus.i_req1_data : bus.i_req0_data;
  assign w_hs_last   = grant_q[1] ? bus.i_req1_last : bus.i_req0_last;
  // Receive strobes that do not answer an issued byte are dropped.
  assign w_rx        = (state_q == c_XFER) && pending_q && bus.i_phy_rx_valid;
  assign w_any_req   = bus.i_req0_valid || bus.i_req1_valid;
  // Port 1 wins when alone or when port 0 was granted last.
  assign w_pick1     = bus.i_req1_valid && (!bus.i_req0_valid || !last_grant_q);

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= c_IDLE;
      cnt_q        <= '0;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      pending_q    <= 1'b0;
      last_flag_q  <= 1'b0;
      cs_n_q       <= 1'b1;
      phy_wr_q     <= 1'b0;
      phy_data_q   <= 8'h00;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 8'h00;
      rsp1_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      last_flag_q  <= last_flag_d;
      cs_n_q       <= cs_n_d;
      phy_wr_q     <= phy_wr_d;
      phy_data_q   <= phy_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // The XFER handshake cycle is itself the last setup cycle, so SETUP
      // lasts CS_SETUP-1 cycles and is skipped entirely when CS_SETUP is 1.
      c_IDLE:  if (w_any_req) state_d = (CS_SETUP == 1) ? c_XFER : c_SETUP;
      c_SETUP: if (cnt_q <= c_CNT_ONE) state_d = c_XFER;
      c_XFER:  if (w_rx && last_flag_q) state_d = c_HOLD;
      c_HOLD:  if (cnt_q == '0) state_d = c_GAP;
      c_GAP:   if (cnt_q == '0) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Registered outputs, counter reloads and in-flight byte bookkeeping.
  always_comb begin
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pending_d    = pending_q;
    last_flag_d  = last_flag_q;
    cs_n_d       = cs_n_q;
    phy_wr_d     = 1'b0;
    phy_data_d   = phy_data_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    case (state_q)
      c_IDLE: begin
        if (w_any_req) begin
          grant_d      = w_pick1 ? 2'b10 : 2'b01;
          last_grant_d = w_pick1;
          cs_n_d       = 1'b0;
          cnt_d        = c_SETUP_LD;
        end
      end
      c_SETUP: begin
        if (cnt_q != '0) cnt_d = cnt_q - c_CNT_ONE;
      end
      c_XFER: begin
        if (w_hs) begin
          phy_wr_d    = 1'b1;
          phy_data_d  = w_hs_data;
          pending_d   = 1'b1;
          last_flag_d = w_hs_last;
        end
        if (w_rx) begin
          if (grant_q[1]) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = bus.i_phy_rx_data;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = bus.i_phy_rx_data;
          end
          pending_d = 1'b0;
          if (last_flag_q) cnt_d = c_HOLD_LD;
        end
      end
      c_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          grant_d = 2'b00;
          cnt_d   = c_GAP_LD;
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end
      c_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - c_CNT_ONE;
      end
      default: ;
    endcase
  end

  assign bus.o_req0_ready = w_ready0;
  assign bus.o_req1_ready = w_ready1;
  assign bus.o_rsp0_valid = rsp0_valid_q;
  assign bus.o_rsp0_data  = rsp0_data_q;
  assign bus.o_rsp1_valid = rsp1_valid_q;
  assign bus.o_rsp1_data  = rsp1_data_q;
  assign bus.o_phy_wr     = phy_wr_q;
  assign bus.o_phy_data   = phy_data_q;
  assign bus.o_cs_n       = cs_n_q;
  assign bus.o_grant      = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xact_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xact_arbiter
// Brief    : Directed testbench for spi_xact_arbiter with a requester queue
//            driver and a fixed-latency PHY model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_xact_arbiter;

  localparam int c_PHY_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xact_arbiter_if bus();

  spi_xact_arbiter #(.CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] echo_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] rsp0_q[$];
  logic [7:0] rsp1_q[$];
  int         wr_t[$];
  int         rsp0_t[$];
  int         fall_log[$];
  int         rise_log[$];
  logic [1:0] grant_log[$];
  int         rdy_cnt = 0;

  logic       phy_busy  = 1'b0;
  logic       hold_busy = 1'b0;
  logic       rx_m      = 1'b0;
  logic       spur      = 1'b0;
  logic [7:0] rx_data_m = 8'h00;
  int         phy_cnt   = 0;
  logic       cs_prev   = 1'b1;
  logic [1:0] grant_prev = 2'b00;

  // Present queue heads and PHY model state on the bus.
  task automatic drive();
    bus.i_req0_valid   = (q0.size() > 0);
    bus.i_req0_data    = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.i_req0_last    = (q0.size() > 0) ? q0[0][8]   : 1'b0;
    bus.i_req1_valid   = (q1.size() > 0);
    bus.i_req1_data    = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.i_req1_last    = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    bus.i_phy_busy     = phy_busy | hold_busy;
    bus.i_phy_rx_valid = rx_m | spur;
    bus.i_phy_rx_data  = spur ? 8'h55 : rx_data_m;
  endtask

  // One clock: note handshakes at the falling edge, then monitor outputs,
  // step the PHY model and redrive inputs just after the rising edge.
  task automatic cyc();
    logic hs0, hs1;
    @(negedge clk);
    hs0 = bus.i_req0_valid && bus.o_req0_ready;
    hs1 = bus.i_req1_valid && bus.o_req1_ready;
    if (bus.o_req0_ready) rdy_cnt++;
    if (bus.o_req1_ready) rdy_cnt++;
    @(posedge clk);
    #1;
    cyc_n++;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    rx_m = 1'b0;
    if (bus.o_phy_wr) begin
      wr_q.push_back(bus.o_phy_data);
      wr_t.push_back(cyc_n);
      phy_cnt  = c_PHY_LAT;
      phy_busy = 1'b1;
    end else if (phy_cnt > 0) begin
      phy_cnt--;
      if (phy_cnt == 0) begin
        phy_busy  = 1'b0;
        rx_m      = 1'b1;
        rx_data_m = (echo_q.size() > 0) ? echo_q.pop_front() : 8'hEE;
      end
    end
    if (bus.o_rsp0_valid) begin
      rsp0_q.push_back(bus.o_rsp0_data);
      rsp0_t.push_back(cyc_n);
    end
    if (bus.o_rsp1_valid) rsp1_q.push_back(bus.o_rsp1_data);
    if (cs_prev && !bus.o_cs_n) fall_log.push_back(cyc_n);
    if (!cs_prev && bus.o_cs_n) rise_log.push_back(cyc_n);
    cs_prev = bus.o_cs_n;
    if (grant_prev == 2'b00 && bus.o_grant != 2'b00) grant_log.push_back(bus.o_grant);
    grant_prev = bus.o_grant;
    drive();
  endtask

  task automatic clear_logs();
    echo_q.delete(); wr_q.delete(); wr_t.delete(); rsp0_q.delete(); rsp0_t.delete();
    rsp1_q.delete(); fall_log.delete(); rise_log.delete(); grant_log.delete();
    rdy_cnt = 0;
  endtask

  // Run until n chip-select releases have been logged or the budget runs out.
  task automatic wait_rise(input int n, input int budget, input string name);
    for (int i = 0; i < budget && rise_log.size() < n; i++) cyc();
    total++;
    if (rise_log.size() < n) begin
      bad++;
      $display("FAIL %s timeout: cs releases got %0d want %0d", name, rise_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive();
    cyc(); cyc();
    total++; if (bus.o_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", bus.o_cs_n); end
    total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", bus.o_grant); end
    total++; if (bus.o_phy_wr !== 1'b0) begin bad++; $display("FAIL rst_phy_wr: got %b want 0", bus.o_phy_wr); end
    total++; if (bus.o_phy_data !== 8'h00) begin bad++; $display("FAIL rst_phy_data: got %h want 00", bus.o_phy_data); end
    total++; if (bus.o_rsp0_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp0_valid: got %b want 0", bus.o_rsp0_valid); end
    total++; if (bus.o_rsp0_data !== 8'h00) begin bad++; $display("FAIL rst_rsp0_data: got %h want 00", bus.o_rsp0_data); end
    total++; if (bus.o_rsp1_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp1_valid: got %b want 0", bus.o_rsp1_valid); end
    total++; if (bus.o_rsp1_data !== 8'h00) begin bad++; $display("FAIL rst_rsp1_data: got %h want 00", bus.o_rsp1_data); end
    total++; if (bus.o_req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0: got %b want 0", bus.o_req0_ready); end
    total++; if (bus.o_req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1: got %b want 0", bus.o_req1_ready); end
    rst = 1'b0;
    drive();
    cyc();
    clear_logs();
  endtask

  // Both ports request together straight after reset: port 0 first, then port 1.
  task automatic test_tie();
    rst = 1'b1; drive(); cyc();
    rst = 1'b0; drive(); cyc();
    clear_logs();
    echo_q.push_back(8'hE0); echo_q.push_back(8'hE1);
    q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h22});
    drive();
    wait_rise(2, 100, "tie");
    total++; if (grant_log.size() !== 2) begin bad++; $display("FAIL tie_grants: got %0d grants want 2", grant_log.size()); end
    total++; if (grant_log[0] !== 2'b01) begin bad++; $display("FAIL tie_first_grant: got %b want 01", grant_log[0]); end
    total++; if (grant_log[1] !== 2'b10) begin bad++; $display("FAIL tie_second_grant: got %b want 10", grant_log[1]); end
    total++; if ({wr_q[0], wr_q[1]} !== 16'h1122) begin bad++; $display("FAIL tie_wr_order: got %h%h want 1122", wr_q[0], wr_q[1]); end
    total++; if (fall_log[1] - rise_log[0] !== 5) begin bad++; $display("FAIL tie_gap: got %0d want 5", fall_log[1] - rise_log[0]); end
    total++; if ({rsp0_q[0], rsp1_q[0]} !== 16'hE0E1) begin bad++; $display("FAIL tie_rsp: got %h%h want e0e1", rsp0_q[0], rsp1_q[0]); end
    repeat (7) cyc();
  endtask

  task automatic test_single_byte();
    clear_logs();
    echo_q.push_back(8'hC2);
    q0.push_back({1'b1, 8'h9F});
    drive();
    wait_rise(1, 40, "single");
    total++; if (wr_q.size() !== 1 || wr_q[0] !== 8'h9F) begin bad++; $display("FAIL single_wr: got n=%0d d=%h want n=1 d=9f", wr_q.size(), wr_q[0]); end
    total++; if (wr_t[0] - fall_log[0] !== 2) begin bad++; $display("FAIL single_cs_setup: got %0d want 2", wr_t[0] - fall_log[0]); end
    total++; if (rsp0_q.size() !== 1 || rsp0_q[0] !== 8'hC2) begin bad++; $display("FAIL single_rsp0: got n=%0d d=%h want n=1 d=c2", rsp0_q.size(), rsp0_q[0]); end
    total++; if (rise_log[0] - rsp0_t[0] !== 2) begin bad++; $display("FAIL single_cs_hold: got %0d want 2", rise_log[0] - rsp0_t[0]); end
    total++; if (rsp1_q.size() !== 0) begin bad++; $display("FAIL single_rsp1: got %0d strobes want 0", rsp1_q.size()); end
    repeat (7) cyc();
  endtask

  task automatic test_multi_byte();
    clear_logs();
    echo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    q1 = '{{1'b0, 8'h03}, {1'b0, 8'h00}, {1'b0, 8'h10}, {1'b1, 8'h00}};
    drive();
    wait_rise(1, 150, "multi");
    total++; if (wr_q.size() !== 4) begin bad++; $display("FAIL multi_wr_count: got %0d want 4", wr_q.size()); end
    total++; if ({wr_q[0], wr_q[1], wr_q[2], wr_q[3]} !== 32'h03001000) begin bad++; $display("FAIL multi_wr_data: got %h%h%h%h want 03001000", wr_q[0], wr_q[1], wr_q[2], wr_q[3]); end
    total++; if ({rsp1_q[0], rsp1_q[1], rsp1_q[2], rsp1_q[3]} !== 32'hA1B2C3D4) begin bad++; $display("FAIL multi_rsp1: got %h%h%h%h want a1b2c3d4", rsp1_q[0], rsp1_q[1], rsp1_q[2], rsp1_q[3]); end
    total++; if (rsp1_q.size() !== 4) begin bad++; $display("FAIL multi_rsp1_count: got %0d want 4", rsp1_q.size()); end
    total++; if (rsp0_q.size() !== 0) begin bad++; $display("FAIL multi_rsp0: got %0d strobes want 0", rsp0_q.size()); end
    total++; if (fall_log.size() !== 1) begin bad++; $display("FAIL multi_cs_continuous: got %0d cs falls want 1", fall_log.size()); end
    total++; if (grant_log[0] !== 2'b10) begin bad++; $display("FAIL multi_grant: got %b want 10", grant_log[0]); end
    repeat (7) cyc();
  endtask

  task automatic test_busy_stall();
    clear_logs();
    hold_busy = 1'b1;
    echo_q.push_back(8'h3C);
    q0.push_back({1'b1, 8'h5A});
    drive();
    repeat (12) cyc();
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL busy_ready: got %0d ready cycles want 0", rdy_cnt); end
    total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL busy_wr: got %0d strobes want 0", wr_q.size()); end
    total++; if (bus.o_cs_n !== 1'b0 || bus.o_grant !== 2'b01) begin bad++; $display("FAIL busy_frame_open: got cs_n=%b grant=%b want 0/01", bus.o_cs_n, bus.o_grant); end
    hold_busy = 1'b0;
    drive();
    wait_rise(1, 40, "busy");
    total++; if (wr_q.size() !== 1 || wr_q[0] !== 8'h5A) begin bad++; $display("FAIL busy_wr_after: got n=%0d d=%h want n=1 d=5a", wr_q.size(), wr_q[0]); end
    total++; if (rsp0_q[0] !== 8'h3C) begin bad++; $display("FAIL busy_rsp0: got %h want 3c", rsp0_q[0]); end
    repeat (7) cyc();
  endtask

  task automatic test_reset_midframe();
    int n_rsp;
    clear_logs();
    echo_q = '{8'h71, 8'h72, 8'h73};
    q0 = '{{1'b0, 8'h01}, {1'b0, 8'h02}, {1'b1, 8'h03}};
    drive();
    for (int i = 0; i < 60 && wr_q.size() < 2; i++) cyc();
    total++; if (wr_q.size() < 2) begin bad++; $display("FAIL midrst timeout: wr strobes got %0d want 2", wr_q.size()); end
    n_rsp = rsp0_q.size();
    q0.delete();
    rst = 1'b1;
    drive();
    cyc();
    total++; if (bus.o_cs_n !== 1'b1) begin bad++; $display("FAIL midrst_cs_n: got %b want 1", bus.o_cs_n); end
    total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL midrst_grant: got %b want 00", bus.o_grant); end
    total++; if (bus.o_phy_wr !== 1'b0 || bus.o_req0_ready !== 1'b0) begin bad++; $display("FAIL midrst_wr_ready: got wr=%b rdy=%b want 0/0", bus.o_phy_wr, bus.o_req0_ready); end
    rst = 1'b0;
    drive();
    repeat (10) cyc();
    total++; if (rsp0_q.size() !== n_rsp || n_rsp !== 1) begin bad++; $display("FAIL midrst_late_rsp: got %0d rsp (1 before reset) want 1", rsp0_q.size()); end
    total++; if (fall_log.size() !== 1 || wr_q.size() !== 2) begin bad++; $display("FAIL midrst_no_resume: got falls=%0d wr=%0d want 1/2", fall_log.size(), wr_q.size()); end
  endtask

  task automatic test_spurious_rx();
    clear_logs();
    spur = 1'b1;
    drive();
    cyc();
    spur = 1'b0;
    drive();
    repeat (4) cyc();
    total++; if (rsp0_q.size() !== 0 || rsp1_q.size() !== 0) begin bad++; $display("FAIL spur_rsp: got rsp0=%0d rsp1=%0d want 0/0", rsp0_q.size(), rsp1_q.size()); end
    total++; if (bus.o_cs_n !== 1'b1 || bus.o_grant !== 2'b00 || wr_q.size() !== 0) begin bad++; $display("FAIL spur_idle: got cs_n=%b grant=%b wr=%0d want 1/00/0", bus.o_cs_n, bus.o_grant, wr_q.size()); end
    echo_q.push_back(8'h99);
    q1.push_back({1'b1, 8'h66});
    drive();
    wait_rise(1, 40, "spur_follow");
    total++; if (rsp1_q[0] !== 8'h99 || wr_q[0] !== 8'h66) begin bad++; $display("FAIL spur_follow: got wr=%h rsp1=%h want 66/99", wr_q[0], rsp1_q[0]); end
  endtask

  initial begin
    drive();
    test_reset();
    test_tie();
    test_single_byte();
    test_multi_byte();
    test_busy_stall();
    test_reset_midframe();
    test_spurious_rx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
